// File: rtl/frog_pkg.sv
// Shared types for the Frogger frog tracker.
// Game states, move directions and the lives-counter width helper.
package frog_pkg;

  typedef enum logic [1:0] {
    PLAY,
    SCORED,
    OVER
  } frog_state_t;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_L,
    DIR_U,
    DIR_D,
    DIR_R
  } dir_t;

  function automatic int lives_w(input int max_lives);
    return $clog2(max_lives + 1);
  endfunction

endpackage

// File: rtl/frog_position_button_edge.sv
// Button edge detector: one move per fresh, unambiguous press.
// Ports: clk, reset, load (round reset), L/U/D/R levels, dir request.
module button_edge
  import frog_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic L,
  input  logic U,
  input  logic D,
  input  logic R,
  output dir_t dir
);

  logic [3:0] cur;
  logic [3:0] prev;
  logic [3:0] rise;

  assign cur  = {L, U, D, R};
  assign rise = cur & ~prev;

  // Every cycle reloads history, so reset/load just mirror the
  // normal path; a held button never looks like a new press.
  always_ff @(posedge clk) begin
    if (reset || load) prev <= cur;
    else prev <= cur;
  end

  // A move needs exactly one button down, and that one freshly.
  always_comb begin
    dir = DIR_NONE;
    if ($onehot(cur) && (rise == cur)) begin
      unique case (1'b1)
        cur[3]:  dir = DIR_L;
        cur[2]:  dir = DIR_U;
        cur[1]:  dir = DIR_D;
        cur[0]:  dir = DIR_R;
        default: dir = DIR_NONE;
      endcase
    end
  end

endmodule

// File: rtl/frog_position.sv
// Frog tracker: grid position, moves, collisions, lives and score.
// Ports: clk, reset, resetRound, L/U/D/R, hit -> row, col, frogGrid, scored, score, lives, gameOver.
module frog_position
  import frog_pkg::*;
#(
  parameter  int ROWS      = 8,
  parameter  int COLS      = 8,
  parameter  int START_COL = COLS / 2,
  parameter  int MAX_LIVES = 3,
  parameter  int SCORE_W   = 4,
  localparam int RW        = $clog2(ROWS),
  localparam int CW        = $clog2(COLS),
  localparam int LW        = lives_w(MAX_LIVES)
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resetRound,
  input  logic                 L,
  input  logic                 U,
  input  logic                 D,
  input  logic                 R,
  input  logic                 hit,
  output logic [RW-1:0]        row,
  output logic [CW-1:0]        col,
  output logic [ROWS*COLS-1:0] frogGrid,
  output logic                 scored,
  output logic [SCORE_W-1:0]   score,
  output logic [LW-1:0]        lives,
  output logic                 gameOver
);

  localparam logic [RW-1:0] ROW_TOP = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_PRE = RW'(ROWS - 2);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_ST  = CW'(START_COL);
  localparam logic [LW-1:0] LIV_MAX = LW'(MAX_LIVES);

  frog_state_t state;
  dir_t        dir;

  button_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .load  (resetRound),
    .L     (L),
    .U     (U),
    .D     (D),
    .R     (R),
    .dir   (dir)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row      <= '0;
      col      <= COL_ST;
      state    <= PLAY;
      score    <= '0;
      lives    <= LIV_MAX;
      scored   <= 1'b0;
      gameOver <= 1'b0;
    end else if (resetRound) begin
      if (state != OVER) begin
        row    <= '0;
        col    <= COL_ST;
        state  <= PLAY;
        scored <= 1'b0;
      end
    end else begin
      unique case (state)
        PLAY: begin
          if (hit) begin
            row   <= '0;
            col   <= COL_ST;
            lives <= lives - 1'b1;
            if (lives <= LW'(1)) begin
              state    <= OVER;
              gameOver <= 1'b1;
            end
          end else begin
            unique case (dir)
              DIR_U: begin
                if (row != ROW_TOP) row <= row + 1'b1;
                // Goal row is shown for one cycle before respawn.
                if (row == ROW_PRE) begin
                  state  <= SCORED;
                  scored <= 1'b1;
                end
              end
              DIR_D: if (row != '0) row <= row - 1'b1;
              DIR_L: if (col != '0) col <= col - 1'b1;
              DIR_R: if (col != COL_MAX) col <= col + 1'b1;
              default: ;
            endcase
          end
        end
        SCORED: begin
          row    <= '0;
          col    <= COL_ST;
          state  <= PLAY;
          scored <= 1'b0;
          if (score != '1) score <= score + 1'b1;
        end
        OVER: ;
        default: state <= PLAY;
      endcase
    end
  end

  always_comb begin
    frogGrid = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        frogGrid[i*COLS+j] = (state != OVER) &&
                             (row == RW'(i)) &&
                             (col == CW'(j));
      end
    end
  end

endmodule

// File: tb/tb_frog_position.sv
// Self-checking bench for frog_position on a 4x4 grid.
// Vector table plus scoreboard queue; score saturation sequence.
module tb_frog_position;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        resetRound = 1'b0;
  logic        L = 1'b0, U = 1'b0, D = 1'b0, R = 1'b0;
  logic        hit = 1'b0;
  logic [1:0]  row;
  logic [1:0]  col;
  logic [15:0] frogGrid;
  logic        scored;
  logic [3:0]  score;
  logic [1:0]  lives;
  logic        gameOver;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frog_position #(
    .ROWS      (4),
    .COLS      (4),
    .START_COL (1),
    .MAX_LIVES (2),
    .SCORE_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .resetRound (resetRound),
    .L          (L),
    .U          (U),
    .D          (D),
    .R          (R),
    .hit        (hit),
    .row        (row),
    .col        (col),
    .frogGrid   (frogGrid),
    .scored     (scored),
    .score      (score),
    .lives      (lives),
    .gameOver   (gameOver)
  );

  typedef struct {
    logic [3:0] btn;
    logic       h;
    logic       rr;
    logic       rst;
    int         erow;
    int         ecol;
    int         eliv;
    int         escr;
    int         escd;
    int         eovr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  localparam logic [3:0] BN = 4'b0000;
  localparam logic [3:0] BL = 4'b1000;
  localparam logic [3:0] BU = 4'b0100;
  localparam logic [3:0] BD = 4'b0010;
  localparam logic [3:0] BR = 4'b0001;

  function automatic vec_t mk(logic [3:0] b, logic h, logic rr,
                              logic rst, int r, int c, int lv,
                              int sc, int scd, int ov);
    vec_t v;
    v.btn = b; v.h = h; v.rr = rr; v.rst = rst;
    v.erow = r; v.ecol = c; v.eliv = lv; v.escr = sc;
    v.escd = scd; v.eovr = ov;
    return v;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    vec_t e;
    int   g;
    @(negedge clk);
    {L, U, D, R} = v.btn;
    hit = v.h;
    resetRound = v.rr;
    reset = v.rst;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    g = (e.eovr != 0) ? 0 : (1 << (e.erow * COLS + e.ecol));
    chk("row", idx, int'(row), e.erow);
    chk("col", idx, int'(col), e.ecol);
    chk("lives", idx, int'(lives), e.eliv);
    chk("score", idx, int'(score), e.escr);
    chk("scored", idx, int'(scored), e.escd);
    chk("gameOver", idx, int'(gameOver), e.eovr);
    chk("frogGrid", idx, int'(frogGrid), g);
  endtask

  initial begin
    // reset with U held, then hold U: no move
    tbl.push_back(mk(BU, 0, 0, 1, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BD, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    // D clamp at row 0, L clamp at col 0
    tbl.push_back(mk(BD, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BL, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BL, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BL, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(BR, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    // climb to goal; R during SCORED is ignored
    tbl.push_back(mk(BU, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 2, 1, 2, 0, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 3, 1, 2, 0, 1, 0));
    tbl.push_back(mk(BR, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    // go to (2,3), R clamp, then resetRound
    tbl.push_back(mk(BU, 0, 0, 0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 2, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 2, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BR, 0, 0, 0, 2, 2, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 2, 2, 2, 1, 0, 0));
    tbl.push_back(mk(BR, 0, 0, 0, 2, 3, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 2, 3, 2, 1, 0, 0));
    tbl.push_back(mk(BR, 0, 0, 0, 2, 3, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 2, 3, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 1, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    // resetRound with U held: held U must not move afterwards
    tbl.push_back(mk(BU, 0, 1, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    // L+R together, then release R
    tbl.push_back(mk(BL | BR, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BL, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    // hit with U, second hit -> OVER, OVER ignores inputs
    tbl.push_back(mk(BU, 0, 0, 0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(BU, 1, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(BN, 1, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BN, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BU, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BN, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BN, 1, 0, 0, 0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(BN, 0, 0, 1, 0, 1, 2, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // score saturation: 16 goals, score stops at 15
    for (int k = 1; k <= 16; k++) begin
      int p;
      int n;
      p = (k - 1 > 15) ? 15 : k - 1;
      n = (k > 15) ? 15 : k;
      apply(mk(BU, 0, 0, 0, 1, 1, 2, p, 0, 0), 1000 + k);
      apply(mk(BN, 0, 0, 0, 1, 1, 2, p, 0, 0), 1000 + k);
      apply(mk(BU, 0, 0, 0, 2, 1, 2, p, 0, 0), 1000 + k);
      apply(mk(BN, 0, 0, 0, 2, 1, 2, p, 0, 0), 1000 + k);
      apply(mk(BU, 0, 0, 0, 3, 1, 2, p, 1, 0), 1000 + k);
      apply(mk(BN, 0, 0, 0, 0, 1, 2, n, 0, 0), 1000 + k);
    end

    chk("sb_empty", 0, sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
